// File: rtl/fp_dot_acc.sv
// Purpose : streaming Q1.15 x Q1.15 dot-product accumulator; one Q9.23 saturating sum per frame.
// Latency : a last sample accepted on edge t presents its frame result after edge t+3.
// Backpr. : a held result (out_valid && !out_ready) freezes the whole pipeline and drops in_ready.
//
// Ports: clk/rst (async, active-low) | in_valid/in_ready/in_a/in_b/in_last sample stream |
//        out_valid/out_ready/out_data/out_sat/out_cnt frame result stream.
module fp_dot_acc #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] out_cnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic en;

    // stage 1: raw Q2.30 product
    logic               v1_q, v1_d, l1_q, l1_d;
    logic signed [31:0] p1_q, p1_d;
    // stage 2: requantised Q9.23 term
    logic               v2_q, v2_d, l2_q, l2_d;
    logic signed [31:0] t2_q, t2_d;
    // stage 3: running frame state
    logic signed [31:0] acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // finished-frame register between the accumulator and the output
    logic               res_vld_q, res_vld_d;
    logic [31:0]        res_dat_q, res_dat_d;
    logic               res_sat_q, res_sat_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;
    // output register
    logic               out_vld_q, out_vld_d;
    logic [31:0]        out_dat_q, out_dat_d;
    logic               out_sat_q, out_sat_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;

    logic signed [31:0] a_ext, b_ext, rnd, clamped;
    logic signed [32:0] sum;
    logic               clip;
    logic [CNT_W-1:0]   cnt_inc;

    assign en        = !(out_vld_q && !out_ready);
    assign in_ready  = en;
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_sat   = out_sat_q;
    assign out_cnt   = out_cnt_q;

    always_comb begin
        a_ext = {{16{in_a[15]}}, in_a};
        b_ext = {{16{in_b[15]}}, in_b};
        // -1 x -1 = +2^30 still fits the 32-bit product, so the low word is exact
        p1_d  = a_ext * b_ext;
        v1_d  = v1_q;
        l1_d  = l1_q;
        if (!en) p1_d = p1_q;
        else begin
            v1_d = in_valid;
            l1_d = in_last;
        end

        // +64 then arithmetic shift gives round-half-up (ties go toward +inf)
        rnd  = p1_q + 32'sd64;
        t2_d = t2_q;
        v2_d = v2_q;
        l2_d = l2_q;
        if (en) begin
            t2_d = rnd >>> 7;
            v2_d = v1_q;
            l2_d = l1_q;
        end

        // 33-bit sum; top two bits disagree exactly when the 32-bit range is left
        sum     = {acc_q[31], acc_q} + {t2_q[31], t2_q};
        clip    = sum[32] != sum[31];
        clamped = clip ? (sum[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : sum[31:0];
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        acc_d     = acc_q;
        sat_d     = sat_q;
        cnt_d     = cnt_q;
        res_vld_d = res_vld_q;
        res_dat_d = res_dat_q;
        res_sat_d = res_sat_q;
        res_cnt_d = res_cnt_q;
        if (en) begin
            res_vld_d = v2_q && l2_q;
            if (v2_q) begin
                if (l2_q) begin
                    // close the frame and restart from zero on the same edge
                    res_dat_d = clamped;
                    res_sat_d = sat_q | clip;
                    res_cnt_d = cnt_inc;
                    acc_d     = '0;
                    sat_d     = 1'b0;
                    cnt_d     = '0;
                end else begin
                    acc_d = clamped;
                    sat_d = sat_q | clip;
                    cnt_d = cnt_inc;
                end
            end
        end

        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        out_sat_d = out_sat_q;
        out_cnt_d = out_cnt_q;
        if (en) begin
            // en=1 means the current result is taken (or absent), so valid follows the feed
            out_vld_d = res_vld_q;
            if (res_vld_q) begin
                out_dat_d = res_dat_q;
                out_sat_d = res_sat_q;
                out_cnt_d = res_cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q      <= 1'b0;
            l1_q      <= 1'b0;
            p1_q      <= '0;
            v2_q      <= 1'b0;
            l2_q      <= 1'b0;
            t2_q      <= '0;
            acc_q     <= '0;
            sat_q     <= 1'b0;
            cnt_q     <= '0;
            res_vld_q <= 1'b0;
            res_dat_q <= '0;
            res_sat_q <= 1'b0;
            res_cnt_q <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_sat_q <= 1'b0;
            out_cnt_q <= '0;
        end else begin
            v1_q      <= v1_d;
            l1_q      <= l1_d;
            p1_q      <= p1_d;
            v2_q      <= v2_d;
            l2_q      <= l2_d;
            t2_q      <= t2_d;
            acc_q     <= acc_d;
            sat_q     <= sat_d;
            cnt_q     <= cnt_d;
            res_vld_q <= res_vld_d;
            res_dat_q <= res_dat_d;
            res_sat_q <= res_sat_d;
            res_cnt_q <= res_cnt_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
            out_sat_q <= out_sat_d;
            out_cnt_q <= out_cnt_d;
        end
    end
endmodule

// File: tb/tb_fp_dot_acc.sv
// Bench for fp_dot_acc: directed frames plus random frames with random backpressure,
// scored against an arithmetic model of the frame dot-product.
module tb_fp_dot_acc;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, in_last;
    logic [15:0]      in_a, in_b;
    logic             out_valid, out_ready, out_sat;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_cnt;
    logic             fix_rdy, rand_rdy;
    logic             rnd_rdy = 1'b1;

    assign out_ready = rand_rdy ? rnd_rdy : fix_rdy;

    fp_dot_acc #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat),
        .out_cnt  (out_cnt)
    );

    always #5 clk = ~clk;
    always @(negedge clk) rnd_rdy = ($urandom_range(0, 3) != 0);

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int n_frames_tx = 0, n_rx = 0;

    typedef struct {
        logic [31:0]      dat;
        logic             sat;
        logic [CNT_W-1:0] cnt;
    } res_t;
    res_t        exp_q[$];
    res_t        cur;
    logic [31:0] rx_dat[$];
    logic        rx_sat[$];
    logic [31:0] rx_cnt[$];

    longint m_acc;
    logic   m_sat;
    int     m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_acc = 0;
        m_sat = 1'b0;
        m_cnt = 0;
    endfunction

    // frame sum of round-half-up(a*b / 128), clamped to int32 after every term
    function automatic void model_accept(input logic [15:0] a, input logic [15:0] b, input logic last);
        longint p, x, t;
        res_t   r;
        p = longint'($signed(a)) * longint'($signed(b));
        x = p + 64;
        t = (x >= 0) ? x / 128 : -((-x + 127) / 128);
        m_acc = m_acc + t;
        if (m_acc > 64'sd2147483647) begin
            m_acc = 64'sd2147483647;
            m_sat = 1'b1;
        end else if (m_acc < -64'sd2147483648) begin
            m_acc = -64'sd2147483648;
            m_sat = 1'b1;
        end
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (last) begin
            r.dat = m_acc[31:0];
            r.sat = m_sat;
            r.cnt = CNT_W'(m_cnt);
            exp_q.push_back(r);
            n_frames_tx++;
            model_reset();
        end
    endfunction

    // result monitor: every delivered result against the model, held results against the head
    always @(negedge clk) begin
        #2;
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", exp_q.size(), 32'd1);
            else begin
                cur = exp_q.pop_front();
                check("res_dat", out_data, cur.dat);
                check("res_sat", 32'(out_sat), 32'(cur.sat));
                check("res_cnt", 32'(out_cnt), 32'(cur.cnt));
            end
            rx_dat.push_back(out_data);
            rx_sat.push_back(out_sat);
            rx_cnt.push_back(32'(out_cnt));
            n_rx++;
        end else if (rst && out_valid && exp_q.size() > 0) begin
            check("hold_dat", out_data, exp_q[0].dat);
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        #1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            model_accept(a, b, last);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bubble();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 2000) begin
            @(negedge clk);
            #3;
            guard++;
        end
        check("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        int base;
        int len;
        rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
        fix_rdy = 1'b0; rand_rdy = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_out_cnt", 32'(out_cnt), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        fix_rdy = 1'b1;

        // four 0.25 products, latency of the last sample
        for (int i = 0; i < 3; i++) send(16'h4000, 16'h4000, 1'b0);
        send(16'h4000, 16'h4000, 1'b1);
        in_valid = 1'b0;
        check("lat_t0", 32'(out_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("lat_t2", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("lat_t3", 32'(out_valid), 32'd1);
        drain();
        check("f4_dat", rx_dat[$], 32'h0080_0000);
        check("f4_sat", 32'(rx_sat[$]), 32'd0);
        check("f4_cnt", rx_cnt[$], 32'd4);

        // -1 x -1 single-sample frame
        send(16'h8000, 16'h8000, 1'b1);
        in_valid = 1'b0;
        drain();
        check("neg1_dat", rx_dat[$], 32'h0080_0000);
        check("neg1_cnt", rx_cnt[$], 32'd1);

        // rounding corners
        base = rx_dat.size();
        send(16'h0001, 16'h0040, 1'b1);
        send(16'h0001, 16'h003F, 1'b1);
        send(16'hFFFF, 16'h0040, 1'b1);
        send(16'hFFFF, 16'h00C0, 1'b1);
        in_valid = 1'b0;
        drain();
        check("rnd_half_up", rx_dat[base], 32'h0000_0001);
        check("rnd_below", rx_dat[base+1], 32'h0000_0000);
        check("rnd_neg_tie", rx_dat[base+2], 32'h0000_0000);
        check("rnd_neg", rx_dat[base+3], 32'hFFFF_FFFF);

        // positive saturation, then a clean frame
        for (int i = 0; i < 300; i++) send(16'h8000, 16'h8000, i == 299);
        send(16'h4000, 16'h4000, 1'b1);
        in_valid = 1'b0;
        drain();
        check("sat_dat", rx_dat[$-1], 32'h7FFF_FFFF);
        check("sat_flag", 32'(rx_sat[$-1]), 32'd1);
        check("sat_cnt", rx_cnt[$-1], 32'd300);
        check("post_sat_dat", rx_dat[$], 32'h0020_0000);
        check("post_sat_flag", 32'(rx_sat[$]), 32'd0);

        // two frames against a stalled sink
        @(negedge clk);
        fix_rdy = 1'b0;
        base = rx_dat.size();
        send(16'h4000, 16'h4000, 1'b0);
        send(16'h4000, 16'h4000, 1'b1);
        send(16'h2000, 16'h4000, 1'b0);
        send(16'h2000, 16'h4000, 1'b1);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_out_data", out_data, 32'h0040_0000);
        @(negedge clk);
        fix_rdy = 1'b1;
        drain();
        check("stall_rx_count", rx_dat.size(), base + 2);
        check("stall_first", rx_dat[base], 32'h0040_0000);
        check("stall_second", rx_dat[base+1], 32'h0020_0000);

        // reset in the middle of a frame
        for (int i = 0; i < 3; i++) send(16'h1000, 16'h1000, 1'b0);
        in_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_cnt", 32'(out_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        send(16'h4000, 16'h4000, 1'b0);
        send(16'h4000, 16'h4000, 1'b1);
        in_valid = 1'b0;
        drain();
        check("post_rst_dat", rx_dat[$], 32'h0040_0000);
        check("post_rst_cnt", rx_cnt[$], 32'd2);

        // random frames, random bubbles, random sink readiness
        rand_rdy = 1'b1;
        for (int f = 0; f < 25; f++) begin
            len = $urandom_range(1, 8);
            for (int s = 0; s < len; s++) begin
                send(16'($urandom), 16'($urandom), s == len - 1);
                if ($urandom_range(0, 3) == 0) bubble();
            end
        end
        in_valid = 1'b0;
        drain();
        rand_rdy = 1'b0;

        check("rx_total", n_rx, n_frames_tx);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed %0d results expected %0d", n_rx, n_frames_tx);
        $fatal(1, "simulation time limit");
    end
endmodule
